// File: rtl/audio_pkg.sv
// Shared encodings for the audio scheduler: FSM states,
// track ids and request bit positions.
package audio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BGM  = 2'd1,
    ST_SFX  = 2'd2
  } state_t;

  localparam logic [1:0] TRK_BGM  = 2'd0;
  localparam logic [1:0] TRK_OK   = 2'd1;
  localparam logic [1:0] TRK_ERR  = 2'd2;
  localparam logic [1:0] TRK_OVER = 2'd3;

  localparam int REQ_OK   = 0;
  localparam int REQ_ERR  = 1;
  localparam int REQ_OVER = 2;

endpackage

// File: rtl/audio_scheduler_beat_tick_gen.sv
// Beat divider: counts 0..TICK_DIV-1 while run is high and
// flags the last count as tick; clr restarts the count.
module beat_tick_gen #(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;
  logic         last;

  assign last = (cnt == LAST);
  assign tick = run & last;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/audio_scheduler.sv
// Beat index owner arbitrating BGM against one-shot SFX clips.
// Optional SFX_PENDING_EN adds a one-deep queue for lower-id requests.
module audio_scheduler
  import audio_pkg::*;
#(
  parameter int TICK_DIV = 12_500_000,
  parameter int BGM_LEN  = 4095,
  parameter int SFX_LEN  = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bgm_en,
  input  logic [2:0]  sfx_req,
  input  logic        mute,
  output logic [11:0] ibeat,
  output logic [1:0]  track,
  output logic        play,
  output logic        sfx_busy
);

  state_t      st, st_n;
  logic [11:0] ibeat_n;
  logic [1:0]  track_n;
  logic [11:0] save, save_n;
  logic        restart;
  logic        tick;
  logic        clr;
  logic        req_v;
  logic [1:0]  req_trk;
  logic [12:0] inc;

`ifdef SFX_PENDING_EN
  logic        pend_v, pend_v_n;
  logic [1:0]  pend_trk, pend_trk_n;
`endif

  assign clr = (st_n != st) | restart;
  assign inc = {1'b0, ibeat} + 13'd1;

  beat_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .run   (st != ST_IDLE),
    .tick  (tick)
  );

  // Several bits may be set at once: highest wins.
  always_comb begin
    req_v   = |sfx_req;
    req_trk = TRK_BGM;
    priority case (1'b1)
      sfx_req[REQ_OVER]: req_trk = TRK_OVER;
      sfx_req[REQ_ERR]:  req_trk = TRK_ERR;
      sfx_req[REQ_OK]:   req_trk = TRK_OK;
      default:           req_trk = TRK_BGM;
    endcase
  end

  always_comb begin
    st_n    = st;
    ibeat_n = ibeat;
    track_n = track;
    save_n  = save;
    restart = 1'b0;
`ifdef SFX_PENDING_EN
    pend_v_n   = pend_v;
    pend_trk_n = pend_trk;
`endif
    unique case (st)
      ST_IDLE: begin
        if (req_v) begin
          st_n    = ST_SFX;
          ibeat_n = '0;
          track_n = req_trk;
          save_n  = '0;
        end else if (bgm_en) begin
          st_n    = ST_BGM;
          ibeat_n = '0;
        end
      end
      ST_BGM: begin
        if (req_v) begin
          st_n    = ST_SFX;
          ibeat_n = '0;
          track_n = req_trk;
          save_n  = (req_trk == TRK_OVER) ? '0 : ibeat;
        end else if (!bgm_en) begin
          st_n    = ST_IDLE;
          ibeat_n = '0;
        end else if (tick) begin
          ibeat_n = (inc == 13'(BGM_LEN)) ? '0 : inc[11:0];
        end
      end
      ST_SFX: begin
        if (req_v && req_trk >= track) begin
          ibeat_n = '0;
          track_n = req_trk;
          restart = 1'b1;
          if (req_trk == TRK_OVER) begin
            save_n = '0;
`ifdef SFX_PENDING_EN
            pend_v_n = 1'b0;
`endif
          end
        end else begin
`ifdef SFX_PENDING_EN
          if (req_v && (!pend_v || req_trk >= pend_trk)) begin
            pend_v_n   = 1'b1;
            pend_trk_n = req_trk;
          end
`endif
          if (tick) begin
            if (inc == 13'(SFX_LEN)) begin
`ifdef SFX_PENDING_EN
              if (pend_v_n) begin
                ibeat_n  = '0;
                track_n  = pend_trk_n;
                restart  = 1'b1;
                pend_v_n = 1'b0;
              end else
`endif
              if (bgm_en) begin
                st_n    = ST_BGM;
                ibeat_n = save;
                track_n = TRK_BGM;
              end else begin
                st_n    = ST_IDLE;
                ibeat_n = '0;
                track_n = TRK_BGM;
              end
            end else begin
              ibeat_n = inc[11:0];
            end
          end
        end
      end
      default: begin
        st_n    = ST_IDLE;
        ibeat_n = '0;
        track_n = TRK_BGM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= ST_IDLE;
      ibeat    <= '0;
      track    <= TRK_BGM;
      save     <= '0;
      play     <= 1'b0;
      sfx_busy <= 1'b0;
    end else begin
      st       <= st_n;
      ibeat    <= ibeat_n;
      track    <= track_n;
      save     <= save_n;
      play     <= (st_n != ST_IDLE) & ~mute;
      sfx_busy <= (st_n == ST_SFX);
    end
  end

`ifdef SFX_PENDING_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_v   <= 1'b0;
      pend_trk <= TRK_BGM;
    end else begin
      pend_v   <= pend_v_n;
      pend_trk <= pend_trk_n;
    end
  end
`endif

endmodule

// File: tb/tb_audio_scheduler.sv
// Randomized and directed bench for audio_scheduler against
// a behavioural model of the scheduling rules.
module tb_audio_scheduler;

  localparam int TD = 4;
  localparam int BL = 16;
  localparam int SL = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        bgm_en;
  logic [2:0]  sfx_req;
  logic        mute;
  logic [11:0] ibeat;
  logic [1:0]  track;
  logic        play;
  logic        sfx_busy;

  int checks = 0;
  int errors = 0;

  // mode: 0 idle, 1 music, 2 effect
  int m_mode, m_beat, m_div, m_save, m_trk, m_pv, m_pt;
  bit m_play;

  audio_scheduler #(
    .TICK_DIV (TD),
    .BGM_LEN  (BL),
    .SFX_LEN  (SL)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bgm_en   (bgm_en),
    .sfx_req  (sfx_req),
    .mute     (mute),
    .ibeat    (ibeat),
    .track    (track),
    .play     (play),
    .sfx_busy (sfx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit en,
                            input logic [2:0] rq, input bit mu);
    int id, nm, nb;
    bit tk, rs;
    if (rst) begin
      m_mode = 0; m_beat = 0; m_div = 0; m_save = 0;
      m_trk = 0; m_pv = 0; m_pt = 0; m_play = 0;
      return;
    end
    id = rq[2] ? 2 : rq[1] ? 1 : rq[0] ? 0 : -1;
    tk = (m_mode != 0) && (m_div == TD - 1);
    nm = m_mode; nb = m_beat; rs = 0;
    if (m_mode != 2 && id >= 0) begin
      nm = 2; nb = 0;
      m_save = (m_mode == 1 && id != 2) ? m_beat : 0;
      m_trk = id + 1;
    end else if (m_mode == 0) begin
      if (en) begin nm = 1; nb = 0; end
    end else if (m_mode == 1) begin
      if (!en) begin nm = 0; nb = 0; end
      else if (tk) nb = (m_beat + 1) % BL;
    end else begin
      if (id >= 0 && id + 1 >= m_trk) begin
        nb = 0; m_trk = id + 1; rs = 1;
        if (id == 2) begin m_save = 0; m_pv = 0; end
      end else begin
`ifdef SFX_PENDING_EN
        if (id >= 0 && (m_pv == 0 || id + 1 >= m_pt)) begin
          m_pv = 1; m_pt = id + 1;
        end
`endif
        if (tk) begin
          if (m_beat == SL - 1) begin
            if (m_pv != 0) begin
              nb = 0; m_trk = m_pt; rs = 1; m_pv = 0;
            end else begin
              nm = en ? 1 : 0;
              nb = en ? m_save : 0;
              m_trk = 0;
            end
          end else begin
            nb = m_beat + 1;
          end
        end
      end
    end
    if (nm != m_mode || rs) m_div = 0;
    else if (m_mode != 0) m_div = (m_div + 1) % TD;
    m_mode = nm;
    m_beat = nb;
    m_play = (nm != 0) && !mu;
  endtask

  task automatic cyc(input bit rst, input bit en,
                     input logic [2:0] rq, input bit mu);
    reset = rst; bgm_en = en; sfx_req = rq; mute = mu;
    @(posedge clk);
    #1;
    model_step(rst, en, rq, mu);
    chk("ibeat", ibeat, m_beat);
    chk("track", track, m_trk);
    chk("play", play, m_play);
    chk("busy", sfx_busy, m_mode == 2);
  endtask

  initial begin
    bit wrapped;
    int prev;
    int n;
    repeat (4) cyc(1, 1, 3'b111, 0);
    chk("rst_ibeat", ibeat, 0);
    chk("rst_track", track, 0);
    chk("rst_play", play, 0);
    chk("rst_busy", sfx_busy, 0);

    wrapped = 0;
    prev = 0;
    for (int i = 0; i < 70; i++) begin
      cyc(0, 1, 3'b000, 0);
      if (prev == BL - 1 && ibeat == 0) wrapped = 1;
      prev = ibeat;
    end
    chk("bgm_wrap", wrapped, 1);
    chk("bgm_play", play, 1);

    n = 0;
    while (m_beat != 9 && n < 100) begin
      cyc(0, 1, 3'b000, 0);
      n++;
    end
    chk("reach9", ibeat, 9);
    cyc(0, 1, 3'b010, 0);
    chk("sfx_trk", track, 2);
    chk("sfx_beat", ibeat, 0);
    chk("sfx_busy", sfx_busy, 1);
    repeat (16) cyc(0, 1, 3'b000, 0);
    chk("resume_trk", track, 0);
    chk("resume_beat", ibeat, 9);

    cyc(0, 1, 3'b011, 0);
    chk("multi_trk", track, 2);
    repeat (5) cyc(0, 1, 3'b000, 0);
    cyc(0, 1, 3'b100, 0);
    chk("over_trk", track, 3);
    chk("over_beat", ibeat, 0);
    repeat (3) cyc(0, 1, 3'b000, 0);
    cyc(0, 1, 3'b001, 0);
    chk("low_ignored", track, 3);
    repeat (12) cyc(0, 1, 3'b000, 0);
`ifdef SFX_PENDING_EN
    chk("pend_trk", track, 1);
    chk("pend_beat", ibeat, 0);
    repeat (16) cyc(0, 1, 3'b000, 0);
`endif
    chk("save_clr_trk", track, 0);
    chk("save_clr_beat", ibeat, 0);

    repeat (9) cyc(0, 1, 3'b000, 1);
    chk("mute_play", play, 0);
    chk("mute_beat", ibeat, 2);

    cyc(0, 1, 3'b001, 0);
    repeat (16) cyc(0, 0, 3'b000, 0);
    chk("end_idle_busy", sfx_busy, 0);
    chk("end_idle_beat", ibeat, 0);
    chk("end_idle_play", play, 0);

    for (int i = 0; i < 3000; i++) begin
      bit r, e, m;
      logic [2:0] q;
      r = ($urandom_range(0, 499) == 0);
      e = ($urandom_range(0, 19) != 0);
      m = ($urandom_range(0, 7) == 0);
      q = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      cyc(r, e, q, m);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
